// File: rtl/controlador_display.sv
// Two-digit multiplexed 7-segment driver for a 0..15 counter value, with
// 15 -> 0 wrap detection and a mod-16 wrap counter.
module controlador_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap,
  output logic [3:0] wraps
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {UNID, DEZ} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [3:0]    val_q;
  logic [1:0]    an_q;
  logic [6:0]    seg_q, seg_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    wraps_q;
  logic          scan_last;
  logic          tens;
  logic [3:0]    units;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'h3F;
      4'd1:    enc7 = 7'h06;
      4'd2:    enc7 = 7'h5B;
      4'd3:    enc7 = 7'h4F;
      4'd4:    enc7 = 7'h66;
      4'd5:    enc7 = 7'h6D;
      4'd6:    enc7 = 7'h7D;
      4'd7:    enc7 = 7'h07;
      4'd8:    enc7 = 7'h7F;
      4'd9:    enc7 = 7'h6F;
      default: enc7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    scan_last = (scan_q == LAST);
    scan_d    = scan_last ? '0 : scan_q + 1'b1;
    state_d   = state_q;
    if (scan_last) state_d = (state_q == UNID) ? DEZ : UNID;
    tens  = (val_q >= 4'd10);
    units = tens ? (val_q - 4'd10) : val_q;
    // Segments follow the digit selected after this edge, so an/seg stay aligned.
    seg_d  = (state_d == UNID) ? enc7(units) : (tens ? 7'h06 : 7'h00);
    wrap_d = en && (val_q == 4'hF) && (count == 4'h0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q   <= '0;
      state_q <= UNID;
      scan_q  <= '0;
      an_q    <= 2'b01;
      seg_q   <= 7'h3F;
      wrap_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      if (en) val_q <= count;
      scan_q  <= scan_d;
      state_q <= state_d;
      an_q    <= (state_d == UNID) ? 2'b01 : 2'b10;
      seg_q   <= seg_d;
      wrap_q  <= wrap_d;
      if (wrap_d) wraps_q <= wraps_q + 4'd1;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign wrap  = wrap_q;
  assign wraps = wraps_q;

endmodule

// File: tb/tb_controlador_display.sv
// Directed table-driven bench for controlador_display with SCAN_DIV=4.
module tb_controlador_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] count = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;
  logic [3:0] wraps;

  int checks = 0;
  int failures = 0;

  controlador_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .count (count),
    .seg   (seg),
    .an    (an),
    .wrap  (wrap),
    .wraps (wraps)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] cnt;
    logic [1:0] an;
    logic [6:0] seg;
    logic       wrap;
    logic [3:0] wraps;
  } vec_t;

  vec_t tv [26];
  logic [6:0] enc [10];

  task automatic step(input logic r, input logic e, input logic [3:0] c);
    reset = r;
    en    = e;
    count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [1:0] ea, input logic [6:0] es,
                         input logic ew, input logic [3:0] ews);
    chk({name, ".an"},    {6'd0, an},    {6'd0, ea});
    chk({name, ".seg"},   {1'b0, seg},   {1'b0, es});
    chk({name, ".wrap"},  {7'd0, wrap},  {7'd0, ew});
    chk({name, ".wraps"}, {4'd0, wraps}, {4'd0, ews});
  endtask

  initial begin
    enc = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    //         rst   en    cnt    an     seg    wrap  wraps
    tv[0]  = '{1'b1, 1'b0, 4'd0,  2'b01, 7'h3F, 1'b0, 4'd0};
    tv[1]  = '{1'b1, 1'b1, 4'd9,  2'b01, 7'h3F, 1'b0, 4'd0};
    tv[2]  = '{1'b0, 1'b0, 4'd0,  2'b01, 7'h3F, 1'b0, 4'd0};
    tv[3]  = '{1'b0, 1'b0, 4'd0,  2'b01, 7'h3F, 1'b0, 4'd0};
    tv[4]  = '{1'b0, 1'b0, 4'd0,  2'b01, 7'h3F, 1'b0, 4'd0};
    tv[5]  = '{1'b0, 1'b0, 4'd0,  2'b10, 7'h00, 1'b0, 4'd0};
    tv[6]  = '{1'b0, 1'b1, 4'd7,  2'b10, 7'h00, 1'b0, 4'd0};
    tv[7]  = '{1'b0, 1'b0, 4'd0,  2'b10, 7'h00, 1'b0, 4'd0};
    tv[8]  = '{1'b0, 1'b0, 4'd0,  2'b10, 7'h00, 1'b0, 4'd0};
    tv[9]  = '{1'b0, 1'b0, 4'd0,  2'b01, 7'h07, 1'b0, 4'd0};
    tv[10] = '{1'b0, 1'b1, 4'd13, 2'b01, 7'h07, 1'b0, 4'd0};
    tv[11] = '{1'b0, 1'b0, 4'd0,  2'b01, 7'h4F, 1'b0, 4'd0};
    tv[12] = '{1'b0, 1'b0, 4'd0,  2'b01, 7'h4F, 1'b0, 4'd0};
    tv[13] = '{1'b0, 1'b0, 4'd0,  2'b10, 7'h06, 1'b0, 4'd0};
    tv[14] = '{1'b0, 1'b0, 4'd0,  2'b10, 7'h06, 1'b0, 4'd0};
    tv[15] = '{1'b0, 1'b1, 4'd14, 2'b10, 7'h06, 1'b0, 4'd0};
    tv[16] = '{1'b0, 1'b1, 4'd15, 2'b10, 7'h06, 1'b0, 4'd0};
    tv[17] = '{1'b0, 1'b1, 4'd0,  2'b01, 7'h6D, 1'b1, 4'd1};
    tv[18] = '{1'b0, 1'b1, 4'd0,  2'b01, 7'h3F, 1'b0, 4'd1};
    tv[19] = '{1'b0, 1'b1, 4'd15, 2'b01, 7'h3F, 1'b0, 4'd1};
    tv[20] = '{1'b0, 1'b1, 4'd3,  2'b01, 7'h6D, 1'b0, 4'd1};
    tv[21] = '{1'b0, 1'b1, 4'd14, 2'b10, 7'h00, 1'b0, 4'd1};
    tv[22] = '{1'b0, 1'b1, 4'd0,  2'b10, 7'h06, 1'b0, 4'd1};
    tv[23] = '{1'b0, 1'b0, 4'd0,  2'b10, 7'h00, 1'b0, 4'd1};
    tv[24] = '{1'b0, 1'b0, 4'd0,  2'b10, 7'h00, 1'b0, 4'd1};
    tv[25] = '{1'b0, 1'b0, 4'd0,  2'b01, 7'h3F, 1'b0, 4'd1};

    for (int i = 0; i < 26; i++) begin
      step(tv[i].rst, tv[i].en, tv[i].cnt);
      chk_all($sformatf("vec%0d", i), tv[i].an, tv[i].seg, tv[i].wrap, tv[i].wraps);
    end

    // Every value 0..15 on both digits.
    for (int d = 0; d < 16; d++) begin
      logic [3:0] dv;
      logic [6:0] eu, et;
      dv = 4'(d);
      eu = enc[(d >= 10) ? d - 10 : d];
      et = (d >= 10) ? 7'h06 : 7'h00;
      step(1'b0, 1'b1, dv);
      for (int k = 0; k < 8; k++) begin
        step(1'b0, 1'b0, 4'd0);
        if (an == 2'b01) chk($sformatf("sweep%0d_unid", d), {1'b0, seg}, {1'b0, eu});
        else             chk($sformatf("sweep%0d_dez", d),  {1'b0, seg}, {1'b0, et});
      end
    end

    // Seventeen wraps from reset roll wraps over to 1.
    step(1'b1, 1'b0, 4'd0);
    chk("wr_reset.wraps", {4'd0, wraps}, 8'd0);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 4'd15);
      chk($sformatf("wr%0d_pre", i), {7'd0, wrap}, 8'd0);
      step(1'b0, 1'b1, 4'd0);
      chk($sformatf("wr%0d_pulse", i), {7'd0, wrap}, 8'd1);
    end
    chk("wr17.wraps", {4'd0, wraps}, 8'd1);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'd15);
      step(1'b0, 1'b1, 4'd0);
    end
    chk("wr5.wraps", {4'd0, wraps}, 8'd5);
    step(1'b0, 1'b1, 4'd12);
    chk("cap12.wrap", {7'd0, wrap}, 8'd0);

    for (int k = 0; k < 10; k++) begin
      if (an == 2'b10) break;
      step(1'b0, 1'b0, 4'd0);
    end
    chk("wait_dez.an", {6'd0, an}, 8'h02);
    chk("dez12.seg", {1'b0, seg}, 8'h06);

    // Reset during DEZ, with en=1/count=9 competing.
    step(1'b1, 1'b1, 4'd9);
    chk_all("rst_dez", 2'b01, 7'h3F, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 4'd0);
      chk_all($sformatf("post_rst%0d", k), 2'b01, 7'h3F, 1'b0, 4'd0);
    end
    step(1'b0, 1'b0, 4'd0);
    chk_all("post_rst_switch", 2'b10, 7'h00, 1'b0, 4'd0);

    // Reset while the wrap pulse is high.
    step(1'b0, 1'b1, 4'd15);
    step(1'b0, 1'b1, 4'd0);
    chk("pulse.wrap", {7'd0, wrap}, 8'd1);
    step(1'b1, 1'b0, 4'd0);
    chk_all("rst_pulse", 2'b01, 7'h3F, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    chk_all("rst_hold", 2'b01, 7'h3F, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_display.md
CONTROLADOR_DISPLAY -- requirements
Module: controlador_display

Interface
REQ-001 Parameter SCAN_DIV, default 4, meaning: clk cycles each digit stays selected (legal range 2..256).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 en  input  1  sample strobe; when 1, count is captured this edge.
REQ-005 count  input  4  binary value from the upstream 4-bit sequential counter (0..15).
REQ-006 seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
REQ-007 an  output  2  one-hot digit select, active-high: 2'b01 = units, 2'b10 = tens.
REQ-008 wrap  output  1  one-cycle pulse on detected 15 -> 0 transition of the sampled value.
REQ-009 wraps  output  4  number of wrap events, modulo 16.

Function
REQ-010 Holding register val_q SHALL load count on any edge with en=1 and reset=0; otherwise it SHALL hold.
REQ-011 Decimal split SHALL be: tens = 1 and units = val_q-10 when val_q >= 10; else tens = 0 and units = val_q.
REQ-012 Scan FSM SHALL have two states, UNID (an=01) and DEZ (an=10), with a scan counter 0..SCAN_DIV-1.
REQ-013 Scan counter SHALL increment every cycle; on reaching SCAN_DIV-1 it SHALL return to 0 and the FSM SHALL toggle UNID <-> DEZ on the same edge.
REQ-014 an and seg SHALL be registered; each digit SHALL be selected for exactly SCAN_DIV consecutive cycles.
REQ-015 In UNID, seg SHALL show the units digit; in DEZ, seg SHALL show "1" (0x06) when tens=1 and SHALL be 0x00 (leading-zero blank) when tens=0.
REQ-016 Digit encodings SHALL be 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-017 Latency: a value captured at edge N SHALL appear on seg at edge N+1 if its digit is selected at N+1; otherwise when that digit is next selected.
REQ-018 wrap SHALL be 1 for exactly the cycle after an edge where en=1, val_q=15 and count=0; otherwise 0.
REQ-019 wraps SHALL increment (15 -> 0 rollover) on the same edge wrap is set.
REQ-020 Capture with en=1 and count equal to val_q SHALL change nothing (no wrap, no counter change).
REQ-021 Non-adjacent jumps (e.g. 15 -> 3, 14 -> 0) SHALL NOT produce wrap.
REQ-022 Scan FSM SHALL run independently of en; a capture coinciding with a digit switch SHALL show the new value on the newly selected digit at the next edge.

Reset
REQ-023 reset SHALL have priority over en and over the scan counter.
REQ-024 On an edge with reset=1: val_q=0, FSM=UNID, scan counter=0, an=2'b01, seg=0x3F, wrap=0, wraps=0.
REQ-025 Reset asserted mid-scan or mid-pulse SHALL abort the current state; the first post-reset digit switch SHALL occur SCAN_DIV cycles after the last reset edge.
REQ-026 Holding reset for multiple cycles SHALL keep all outputs at reset values.

Verification
REQ-027 Reset 2 cycles, en=0, SCAN_DIV=4 -> an = 01,01,01,01,10,10,10,10,01...; seg=0x3F in UNID, 0x00 in DEZ.
REQ-028 en=1, count=7 one cycle -> next edge: UNID shows 0x07, DEZ shows 0x00; value held after en drops.
REQ-029 Capture count=13 -> UNID shows 0x4F (3), DEZ shows 0x06 (1).
REQ-030 Drive count 14,15,0 with en=1 each cycle -> wrap=1 one cycle after the 0 capture, wraps 0 -> 1; 15 -> 3 jump gives wrap=0.
REQ-031 Seventeen consecutive 15 -> 0 wraps -> wraps reads 1 (mod-16 rollover).
REQ-032 reset=1 during DEZ with val_q=12, wraps=5 -> next edge: an=01, seg=0x3F, wraps=0, wrap=0; reset and en both 1 with count=9 -> val_q stays 0.
